// File: rtl/cordic_pkg.sv
// Shared constants, the core-pipeline tag type and the CORDIC arctangent table
// used by the arbitrated CORDIC block.
package cordic_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int CORE_LAT   = 12;
    localparam int TAG_ID_W   = 4;
    localparam int CW         = 16;
    localparam int CW_FRAC    = 13;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // atan(2^-i) scaled by 2^CW_FRAC; entries past 13 round to zero
    function automatic int atan_tab(input int i);
        case (i)
            0:       return 6434;
            1:       return 3798;
            2:       return 2007;
            3:       return 1019;
            4:       return 511;
            5:       return 256;
            6:       return 128;
            7:       return 64;
            8:       return 32;
            9:       return 16;
            10:      return 8;
            11:      return 4;
            12:      return 2;
            13:      return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_core.sv
// Fully pipelined rotation-mode CORDIC: one quadrant pre-rotation stage,
// LAT-2 micro-rotation stages and one rounding stage, LAT cycles in total.
module cordic_core import cordic_pkg::*; #(
    parameter int WIDTH = DATA_WIDTH,
    parameter int LAT   = CORE_LAT
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] angle,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out
);

    localparam int ITER = LAT - 2;
    localparam int SH   = CW_FRAC - (WIDTH - 2);
    localparam logic signed [CW-1:0] HALF_PI = CW'(12868);
    localparam logic signed [CW-1:0] K_GAIN  = CW'(4975);
    localparam logic signed [CW-1:0] RND     = CW'(1 << (SH - 1));

    logic signed [CW-1:0] x [ITER+1];
    logic signed [CW-1:0] y [ITER+1];
    logic signed [CW-1:0] z [ITER];
    logic signed [CW-1:0] z_in;

    assign z_in = {{(CW-WIDTH){angle[WIDTH-1]}}, angle} << SH;

    // Angles beyond +-pi/2 start from the rotated unit vector so the
    // micro-rotations only ever see a residual inside their convergence range.
    always_ff @(posedge clk) begin
        if (z_in > HALF_PI) begin
            x[0] <= '0;
            y[0] <= K_GAIN;
            z[0] <= z_in - HALF_PI;
        end else if (z_in < -HALF_PI) begin
            x[0] <= '0;
            y[0] <= -K_GAIN;
            z[0] <= z_in + HALF_PI;
        end else begin
            x[0] <= K_GAIN;
            y[0] <= '0;
            z[0] <= z_in;
        end

        for (int i = 0; i < ITER; i++) begin
            if (!z[i][CW-1]) begin
                x[i+1] <= x[i] - (y[i] >>> i);
                y[i+1] <= y[i] + (x[i] >>> i);
                if (i < ITER - 1) z[i+1] <= z[i] - CW'(atan_tab(i));
            end else begin
                x[i+1] <= x[i] + (y[i] >>> i);
                y[i+1] <= y[i] - (x[i] >>> i);
                if (i < ITER - 1) z[i+1] <= z[i] + CW'(atan_tab(i));
            end
        end

        cos_out <= WIDTH'((x[ITER] + RND) >>> SH);
        sin_out <= WIDTH'((y[ITER] + RND) >>> SH);
    end

endmodule

// File: rtl/cordic_arb.sv
// Round-robin, credit-based sharing of one pipelined CORDIC core among NREQ
// requesters, with a per-requester result FIFO holding returned results.
module cordic_arb #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = cordic_pkg::DATA_WIDTH,
    parameter int CORE_LAT   = cordic_pkg::CORE_LAT,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_angle,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [NREQ*DATA_WIDTH-1:0] rsp_cos,
    output logic [NREQ*DATA_WIDTH-1:0] rsp_sin,
    output logic                       busy
);

    import cordic_pkg::tag_t;
    import cordic_pkg::TAG_ID_W;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int ADR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      winner;
    logic                  grant;
    logic [NREQ-1:0]       eligible;
    logic [NREQ-1:0]       issue;
    logic [NREQ-1:0]       push;
    logic [NREQ-1:0]       pop;
    logic [CNT_W-1:0]      inflight [NREQ];
    logic [CNT_W-1:0]      count    [NREQ];
    logic [ADR_W-1:0]      rd_ptr   [NREQ];
    logic [ADR_W-1:0]      wr_ptr   [NREQ];
    logic [DATA_WIDTH-1:0] mem_cos  [NREQ][BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_sin  [NREQ][BUF_DEPTH];
    tag_t                  tags     [CORE_LAT];
    tag_t                  exit_tag;
    logic [DATA_WIDTH-1:0] core_angle;
    logic [DATA_WIDTH-1:0] core_cos;
    logic [DATA_WIDTH-1:0] core_sin;

    assign exit_tag = tags[CORE_LAT-1];

    // A requester may hold at most BUF_DEPTH results between grant and pop,
    // so a returning result always finds room in its FIFO.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] &&
                ((CNT_W+1)'(inflight[i]) + (CNT_W+1)'(count[i]) < (CNT_W+1)'(BUF_DEPTH));
        end
    end

    always_comb begin
        int idx;
        idx    = 0;
        grant  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant && eligible[idx]) begin
                grant  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        core_angle = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            core_angle        = req_angle[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        issue = '0;
        push  = '0;
        pop   = '0;
        for (int i = 0; i < NREQ; i++) begin
            issue[i] = grant && (winner == PTR_W'(i));
            push[i]  = exit_tag.valid && (exit_tag.id == TAG_ID_W'(i));
            pop[i]   = (count[i] != '0) && rsp_ready[i];
        end
    end

    cordic_core #(
        .WIDTH (DATA_WIDTH),
        .LAT   (CORE_LAT)
    ) u_core (
        .clk     (clk),
        .angle   (core_angle),
        .cos_out (core_cos),
        .sin_out (core_sin)
    );

    // The tag pipe mirrors the core latency, so the tag leaving it names the
    // owner of the result the core is presenting in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < CORE_LAT; t++) tags[t] <= '0;
            rr_ptr <= '0;
        end else begin
            tags[0].valid <= grant;
            tags[0].id    <= grant ? TAG_ID_W'(winner) : '0;
            for (int t = 1; t < CORE_LAT; t++) tags[t] <= tags[t-1];
            if (grant) rr_ptr <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                inflight[i] <= '0;
                count[i]    <= '0;
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({issue[i], push[i]})
                    2'b10:   inflight[i] <= inflight[i] + 1'b1;
                    2'b01:   inflight[i] <= inflight[i] - 1'b1;
                    default: inflight[i] <= inflight[i];
                endcase
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
                if (push[i]) wr_ptr[i] <= (wr_ptr[i] == ADR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= (rd_ptr[i] == ADR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_cos[i][wr_ptr[i]] <= core_cos;
                mem_sin[i][wr_ptr[i]] <= core_sin;
            end
        end
    end

    // Empty FIFOs present zero so stale storage never reaches the outputs.
    always_comb begin
        rsp_valid = '0;
        rsp_cos   = '0;
        rsp_sin   = '0;
        busy      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (count[i] != '0) begin
                rsp_valid[i]                           = 1'b1;
                rsp_cos[i*DATA_WIDTH +: DATA_WIDTH]    = mem_cos[i][rd_ptr[i]];
                rsp_sin[i*DATA_WIDTH +: DATA_WIDTH]    = mem_sin[i][rd_ptr[i]];
                busy                                   = 1'b1;
            end
        end
        for (int t = 0; t < CORE_LAT; t++) begin
            if (tags[t].valid) busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_cordic_arb.sv
// Directed and randomized bench for cordic_arb against a transaction-level
// model: outstanding results per requester, round-robin grant and real trig.
module tb_cordic_arb;

    localparam int NREQ  = 2;
    localparam int DW    = 8;
    localparam int LAT   = 12;
    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_angle;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NREQ*DW-1:0] rsp_cos;
    logic [NREQ*DW-1:0] rsp_sin;
    logic               busy;

    always #5 clk = ~clk;

    cordic_arb #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .CORE_LAT   (LAT),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_angle (req_angle),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_cos   (rsp_cos),
        .rsp_sin   (rsp_sin),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int angle;
        int due;
    } txn_t;

    txn_t pend[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   mptr  = 0;
    int   seen_xfer [NREQ];

    function automatic int outstanding(input int id);
        int n;
        n = 0;
        foreach (pend[k]) if (pend[k].id == id) n++;
        return n;
    endfunction

    function automatic int head_idx(input int id);
        for (int k = 0; k < pend.size(); k++) if (pend[k].id == id) return k;
        return -1;
    endfunction

    function automatic int trig_ref(input int angle, input bit want_sin);
        real r;
        r = real'(angle) / 64.0;
        return want_sin ? int'($sin(r) * 64.0) : int'($cos(r) * 64.0);
    endfunction

    function automatic logic [NREQ*DW-1:0] rand_ang();
        return (NREQ*DW)'($urandom);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        total++;
        assert (obs - exp <= 1 && exp - obs <= 1) else begin
            bad++;
            $error("FAIL %s cyc=%0d: got %0d expected %0d (+-1)", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr,
                        input logic [NREQ*DW-1:0] ang);
        logic [NREQ-1:0] exp_valid;
        logic [NREQ-1:0] exp_ready;
        int   g;
        int   h;
        int   idx;
        txn_t t;
        req_valid = v;
        rsp_ready = rr;
        req_angle = ang;
        #1;
        exp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            h = head_idx(i);
            if (h >= 0 && pend[h].due <= cyc) begin
                exp_valid[i] = 1'b1;
                check_near($sformatf("rsp_cos[%0d]", i), int'($signed(rsp_cos[i*DW +: DW])),
                           trig_ref(pend[h].angle, 1'b0));
                check_near($sformatf("rsp_sin[%0d]", i), int'($signed(rsp_sin[i*DW +: DW])),
                           trig_ref(pend[h].angle, 1'b1));
            end
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check_eq("busy", 32'(busy), 32'(pend.size() != 0));
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (g < 0 && v[idx] && outstanding(idx) < DEPTH) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) seen_xfer[i]++;
        for (int i = 0; i < NREQ; i++) if (exp_valid[i] && rr[i]) pend.delete(head_idx(i));
        if (g >= 0) begin
            t.id    = g;
            t.angle = int'($signed(ang[g*DW +: DW]));
            t.due   = cyc + LAT + 1;
            pend.push_back(t);
            mptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int ncyc);
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_angle = '0;
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b1;
        pend.delete();
        mptr = 0;
        cyc  = 0;
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_rsp_cos", 32'(rsp_cos), 32'd0);
        check_eq("reset_rsp_sin", 32'(rsp_sin), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_angle = '0;
        apply_reset(3);

        // angle 0 on requester 0 in cycle 5, result visible in cycle 18
        repeat (5) step(2'b00, 2'b11, rand_ang());
        step(2'b01, 2'b11, {8'($urandom), 8'h00});
        repeat (15) step(2'b00, 2'b11, rand_ang());

        // ~pi/4 on requester 1
        step(2'b10, 2'b11, {8'h32, 8'($urandom)});
        repeat (15) step(2'b00, 2'b11, rand_ang());

        // both requesters streaming: alternation until credits run out
        repeat (24) step(2'b11, 2'b11, rand_ang());
        repeat (16) step(2'b00, 2'b11, rand_ang());

        // requester 1 never drains: it gets exactly DEPTH transfers
        foreach (seen_xfer[i]) seen_xfer[i] = 0;
        repeat (30) step(2'b11, 2'b01, rand_ang());
        check_eq("req1_transfers", 32'(seen_xfer[1]), 32'(DEPTH));
        repeat (16) step(2'b00, 2'b11, rand_ang());

        // FIFO[0] holds one result while the next one arrives and it is popped
        apply_reset(1);
        step(2'b01, 2'b00, rand_ang());
        step(2'b01, 2'b00, rand_ang());
        repeat (12) step(2'b00, 2'b00, rand_ang());
        step(2'b00, 2'b01, rand_ang());
        step(2'b00, 2'b01, rand_ang());
        repeat (4) step(2'b00, 2'b11, rand_ang());

        repeat (400) step(NREQ'($urandom_range(0, 3)), NREQ'($urandom_range(0, 3)), rand_ang());

        // reset with work in flight: nothing may come back afterwards
        repeat (6) step(2'b11, 2'b00, rand_ang());
        apply_reset(1);
        repeat (LAT + 3) step(2'b00, 2'b11, rand_ang());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
